// File: rtl/sdram_arbiter_n.sv
// sdram_arbiter_n: N-client arbiter in front of a single-word SDRAM port.
//  - INIT  : the preload loader (init_*) is passed straight to the memory port.
//  - IDLE  : one arbitration cycle. Fixed-priority clients (HIPRI_MASK) win first.
//            The remaining clients are served round-robin.
//  - ACTIVE: the owner's slice drives mem_*. The owner may keep the grant for up to
//            MAX_BURST transactions with cl_hold.
// Ports:
//  clk, reset (sync, active-high)
//  init_addr/init_we/init_wrdata/init_ac/init_done : preload loader
//  rt_window : only fixed-priority clients may win a new grant while high
//  cl_req/cl_we/cl_hold/cl_addr/cl_wrdata/cl_be  : packed client requests (client k at slice k)
//  cl_grant/cl_ac/cl_rddata                      : grant one-hot, accept pulse, broadcast read data
//  in_init   : high in INIT
//  mem_*     : Avalon-like single-word memory port (mem_ac completes the transfer, same-cycle read data)
module sdram_arbiter_n #(
  parameter int                     NUM_CLIENTS = 4,
  parameter int                     ADDR_W      = 25,
  parameter int                     DATA_W      = 16,
  parameter int                     BE_W        = 2,
  parameter logic [NUM_CLIENTS-1:0] HIPRI_MASK  = NUM_CLIENTS'(4'b0011),
  parameter int                     MAX_BURST   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             init_addr,
  input  logic                          init_we,
  input  logic [DATA_W-1:0]             init_wrdata,
  output logic                          init_ac,
  input  logic                          init_done,
  input  logic                          rt_window,
  input  logic [NUM_CLIENTS-1:0]        cl_req,
  input  logic [NUM_CLIENTS-1:0]        cl_we,
  input  logic [NUM_CLIENTS-1:0]        cl_hold,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wrdata,
  input  logic [NUM_CLIENTS*BE_W-1:0]   cl_be,
  output logic [NUM_CLIENTS-1:0]        cl_grant,
  output logic [NUM_CLIENTS-1:0]        cl_ac,
  output logic [DATA_W-1:0]             cl_rddata,
  output logic                          in_init,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [BE_W-1:0]               mem_be,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [DATA_W-1:0]             mem_wrdata,
  input  logic                          mem_ac,
  input  logic [DATA_W-1:0]             mem_rddata
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  // Client slices viewed as packed arrays; element k is bits [k*W +: W].
  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_CLIENTS-1:0][DATA_W-1:0] wdata_a;
  logic [NUM_CLIENTS-1:0][BE_W-1:0]   be_a;
  assign addr_a  = cl_addr;
  assign wdata_a = cl_wrdata;
  assign be_a    = cl_be;

  // Eligibility: the real-time window masks out everyone but the fixed-priority class.
  logic [NUM_CLIENTS-1:0] elig;
  for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_elig
    assign elig[k] = cl_req[k] & (HIPRI_MASK[k] | ~rt_window);
  end

  // Winner selection (meaningful only in IDLE).
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] scan;
  int               s;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = '0;
    s         = 0;
    // Downward scan so the lowest-index fixed-priority requester is the last one written.
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (elig[i] && HIPRI_MASK[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    if (!sel_found) begin
      // Round-robin starts one past the last non-HIPRI owner; wrap by compare so
      // non-power-of-two client counts work.
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        s = int'(rr_ptr_q) + 1 + i;
        if (s >= NUM_CLIENTS) s = s - NUM_CLIENTS;
        scan = IDX_W'(s);
        if (!sel_found && elig[scan] && !HIPRI_MASK[scan]) begin
          sel_found = 1'b1;
          sel_idx   = scan;
        end
      end
    end
  end

  logic own_req, own_hold, rt_cut, burst_room;
  assign own_req    = cl_req[owner_q];
  assign own_hold   = cl_hold[owner_q];
  // A raised window ends a non-HIPRI burst at the next boundary; no preemption mid-transfer.
  assign rt_cut     = rt_window & ~HIPRI_MASK[owner_q];
  assign burst_room = burst_cnt_q < CNT_W'(MAX_BURST - 1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_INIT;
      owner_q     <= '0;
      rr_ptr_q    <= IDX_W'(NUM_CLIENTS - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      S_INIT: if (init_done) state_d = S_IDLE;
      S_IDLE: begin
        if (sel_found) begin
          state_d     = S_ACTIVE;
          owner_d     = sel_idx;
          burst_cnt_d = '0;
          if (!HIPRI_MASK[sel_idx]) rr_ptr_d = sel_idx;
        end
      end
      S_ACTIVE: begin
        if (mem_ac) begin
          if (own_hold && burst_room && !rt_cut) burst_cnt_d = burst_cnt_q + CNT_W'(1);
          else                                   state_d     = S_IDLE;
        end else if (!own_req && (!own_hold || rt_cut)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Outputs
  assign in_init   = (state_q == S_INIT);
  assign cl_rddata = mem_rddata;

  always_comb begin
    mem_addr   = '0;
    mem_wrdata = '0;
    mem_be     = '1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    init_ac    = 1'b0;
    cl_ac      = '0;
    cl_grant   = '0;
    case (state_q)
      S_INIT: begin
        mem_addr   = init_addr;
        mem_wrdata = init_wrdata;
        mem_write  = init_we;
        init_ac    = mem_ac;
      end
      S_ACTIVE: begin
        cl_grant[owner_q] = 1'b1;
        mem_addr          = addr_a[owner_q];
        mem_wrdata        = wdata_a[owner_q];
        mem_be            = be_a[owner_q];
        mem_read          = own_req & ~cl_we[owner_q];
        mem_write         = own_req & cl_we[owner_q];
        cl_ac[owner_q]    = mem_ac;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter_n.sv
// Directed steps from the test plan, then a randomized phase checked against a
// cycle-level behavioural model of the arbitration rules.
module tb_sdram_arbiter_n;
  localparam int N  = 4;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int MB = 4;
  localparam logic [N-1:0] HP = 4'b0011;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] init_addr;
  logic          init_we;
  logic [DW-1:0] init_wrdata;
  logic          init_ac;
  logic          init_done;
  logic          rt_window;
  logic [N-1:0]  cl_req, cl_we, cl_hold;
  logic [N*AW-1:0] cl_addr;
  logic [N*DW-1:0] cl_wrdata;
  logic [N*BW-1:0] cl_be;
  logic [N-1:0]  cl_grant, cl_ac;
  logic [DW-1:0] cl_rddata;
  logic          in_init;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_wrdata;
  logic          mem_ac;
  logic [DW-1:0] mem_rddata;

  int checks = 0;
  int failures = 0;

  sdram_arbiter_n #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW),
                    .HIPRI_MASK(HP), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .init_addr(init_addr), .init_we(init_we), .init_wrdata(init_wrdata),
    .init_ac(init_ac), .init_done(init_done), .rt_window(rt_window),
    .cl_req(cl_req), .cl_we(cl_we), .cl_hold(cl_hold), .cl_addr(cl_addr),
    .cl_wrdata(cl_wrdata), .cl_be(cl_be), .cl_grant(cl_grant), .cl_ac(cl_ac),
    .cl_rddata(cl_rddata), .in_init(in_init), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wrdata(mem_wrdata),
    .mem_ac(mem_ac), .mem_rddata(mem_rddata));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of who wins: fixed class by index, else rotate from last RR owner.
  function automatic int pick(input logic [N-1:0] req, input logic rt, input int rr);
    for (int k = 0; k < N; k++) if (req[k] && HP[k]) return k;
    if (rt) return -1;
    for (int j = 1; j <= N; j++) begin
      int c;
      c = (rr + j) % N;
      if (req[c] && !HP[c]) return c;
    end
    return -1;
  endfunction

  // Random-phase client state
  logic [AW-1:0] ra[N];
  logic [DW-1:0] rd[N];
  logic [BW-1:0] rb[N];
  logic [N-1:0]  pend;
  int m_owner, m_rr, m_served, acpulses;

  initial begin
    reset = 1'b1; init_addr = '0; init_we = 1'b0; init_wrdata = '0; init_done = 1'b0;
    rt_window = 1'b0; cl_req = '0; cl_we = '0; cl_hold = '0;
    cl_addr = '0; cl_wrdata = '0; cl_be = '1; mem_ac = 1'b0; mem_rddata = '0;
    for (int k = 0; k < N; k++) cl_addr[k*AW +: AW] = AW'(32'h100 + k);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("reset_in_init", in_init, 1);
    check("reset_grant", cl_grant, 0);
    check("reset_mem_rw", {mem_read, mem_write}, 0);
    check("reset_be", mem_be, 2'b11);

    // ---- Preload pass-through
    init_we = 1'b1; init_addr = 25'h000010; init_wrdata = 16'h5A5A;
    #1;
    check("init_write", mem_write, 1);
    check("init_addr", mem_addr, 25'h10);
    check("init_wdata", mem_wrdata, 16'h5A5A);
    for (int p = 0; p < 3; p++) begin
      tick();
      mem_ac = 1'b1; #1;
      check("init_ac_hi", init_ac, 1);
      check("init_no_clac", cl_ac, 0);
      tick();
      mem_ac = 1'b0; #1;
      check("init_ac_lo", init_ac, 0);
    end
    init_done = 1'b1; #1;
    check("init_still", in_init, 1);
    tick();
    check("init_left", in_init, 0);
    check("idle_no_write", mem_write, 0);
    check("idle_init_ac", init_ac, 0);
    init_we = 1'b0;

    // ---- Fixed priority: 0, 1, then 3, one IDLE bubble each
    cl_req = 4'b1011; cl_we = '0;
    tick();
    check("fp_grant0", cl_grant, 4'b0001);
    check("fp_read0", mem_read, 1);
    check("fp_addr0", mem_addr, 25'h100);
    mem_ac = 1'b1; mem_rddata = 16'hBEEF; #1;
    check("fp_ac0", cl_ac, 4'b0001);
    check("fp_rdata", cl_rddata, 16'hBEEF);
    tick();
    mem_ac = 1'b0; cl_req = 4'b1010; #1;
    check("fp_bubble0", cl_grant, 0);
    tick();
    check("fp_grant1", cl_grant, 4'b0010);
    check("fp_addr1", mem_addr, 25'h101);
    mem_ac = 1'b1; tick();
    mem_ac = 1'b0; cl_req = 4'b1000; #1;
    check("fp_bubble1", cl_grant, 0);
    tick();
    check("fp_grant3", cl_grant, 4'b1000);
    mem_ac = 1'b1; tick();
    mem_ac = 1'b0; cl_req = '0; #1;
    check("fp_idle", cl_grant, 0);

    // ---- Round robin between 2 and 3 (rr_ptr=3 -> scan wraps to 0)
    cl_req = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_grant", cl_grant, (i % 2 == 0) ? 4'b0100 : 4'b1000);
      mem_ac = 1'b1; #1;
      check("rr_ac", cl_ac, cl_grant & {N{1'b1}});
      tick();
      mem_ac = 1'b0; #1;
      check("rr_bubble", cl_grant, 0);
    end

    // ---- Burst limit: client 2 holds, ack every cycle -> exactly MB accepts
    cl_hold = 4'b0100; mem_ac = 1'b1;
    tick();
    acpulses = 0;
    for (int i = 0; i < 8 && cl_grant == 4'b0100; i++) begin
      if (cl_ac[2]) acpulses++;
      tick();
    end
    check("burst_count", acpulses, MB);
    check("burst_idle", cl_grant, 0);
    check("burst_stray_ac", cl_ac, 0);
    cl_hold = '0; mem_ac = 1'b0;
    tick();
    check("burst_next3", cl_grant, 4'b1000);
    mem_ac = 1'b1; tick();
    mem_ac = 1'b0; cl_req = '0;

    // ---- Real-time window
    rt_window = 1'b1; cl_req = 4'b1100;
    tick(); check("rt_block_a", cl_grant, 0);
    tick(); check("rt_block_b", cl_grant, 0);
    cl_req = 4'b1101;
    tick(); check("rt_grant0", cl_grant, 4'b0001);
    mem_ac = 1'b1; tick();
    mem_ac = 1'b0; cl_req = 4'b1100; rt_window = 1'b0; #1;
    check("rt_bubble", cl_grant, 0);
    tick(); check("rt_grant2", cl_grant, 4'b0100);
    mem_ac = 1'b1; tick();
    mem_ac = 1'b0; cl_req = '0; tick();

    // ---- Reset mid-read
    cl_req = 4'b0010;
    tick();
    check("rst_grant1", cl_grant, 4'b0010);
    check("rst_read", mem_read, 1);
    reset = 1'b1; tick();
    reset = 1'b0; cl_req = '0; #1;
    check("rst_read_drop", mem_read, 0);
    check("rst_in_init", in_init, 1);
    check("rst_grant", cl_grant, 0);
    tick();
    check("rst_back_idle", in_init, 0);

    // ---- Randomized phase against the model (DUT is IDLE, rr_ptr reset to N-1)
    pend = '0; m_owner = -1; m_rr = N - 1; m_served = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [N-1:0] exp_g, exp_ac;
      logic [AW-1:0] exp_a;
      logic exp_r, exp_w;
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(99) < 35) begin
          pend[k] = 1'b1;
          cl_we[k] = 1'($urandom);
          ra[k] = AW'($urandom);
          rd[k] = DW'($urandom);
          rb[k] = BW'($urandom);
        end
        cl_hold[k] = ($urandom_range(99) < 50);
        cl_addr[k*AW +: AW]   = ra[k];
        cl_wrdata[k*DW +: DW] = rd[k];
        cl_be[k*BW +: BW]     = rb[k];
      end
      cl_req = pend;
      if ($urandom_range(99) < 8) rt_window = ~rt_window;
      mem_ac = ($urandom_range(99) < 45) && (m_owner < 0 || pend[m_owner]);
      mem_rddata = DW'($urandom);
      #1;
      exp_g = '0; exp_ac = '0; exp_a = '0; exp_r = 1'b0; exp_w = 1'b0;
      if (m_owner >= 0) begin
        exp_g[m_owner]  = 1'b1;
        exp_ac[m_owner] = mem_ac;
        exp_a = ra[m_owner];
        exp_r = pend[m_owner] && !cl_we[m_owner];
        exp_w = pend[m_owner] && cl_we[m_owner];
      end
      check("rnd_grant", cl_grant, exp_g);
      check("rnd_ac", cl_ac, exp_ac);
      check("rnd_rw", {mem_read, mem_write}, {exp_r, exp_w});
      if (m_owner >= 0) check("rnd_addr", mem_addr, exp_a);
      if (exp_w) check("rnd_wdata", mem_wrdata, rd[m_owner]);
      // Advance the model across the coming edge
      if (m_owner < 0) begin
        int p;
        p = pick(cl_req, rt_window, m_rr);
        if (p >= 0) begin
          m_owner = p; m_served = 0;
          if (!HP[p]) m_rr = p;
        end
      end else begin
        int o;
        logic cut;
        o = m_owner;
        cut = rt_window && !HP[o];
        if (mem_ac) begin
          pend[o] = 1'b0;
          m_served++;
          if (!(cl_hold[o] && m_served < MB && !cut)) m_owner = -1;
        end else if (!cl_req[o] && (!cl_hold[o] || cut)) begin
          m_owner = -1;
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
